// File: rtl/serial_parity_rx_pkg.sv
// serial_parity_rx_pkg: shared FSM state encoding and parity-mode constants
package serial_parity_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;
endpackage

// File: rtl/serial_parity_acc.sv
// serial_parity_acc: LSB-first shift register, running XOR and bit counter
module serial_parity_acc #(
  parameter int DATA_W = 4,
  parameter int CW     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_shreg,
  output logic              o_acc,
  output logic [CW-1:0]     o_bit_cnt
);
  logic [DATA_W-1:0] r_shreg;
  logic              r_acc;
  logic [CW-1:0]     r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_acc     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (i_clr) begin
      r_shreg   <= '0;
      r_acc     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_shreg   <= {i_bit, r_shreg[DATA_W-1:1]};
      r_acc     <= r_acc ^ i_bit;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign o_shreg   = r_shreg;
  assign o_acc     = r_acc;
  assign o_bit_cnt = r_bit_cnt;
endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start/data/parity deserialiser with valid/ready output,
// saturating parity-error counter and sticky overrun flag
module serial_parity_rx #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  input  logic              i_out_ready,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_par_calc,
  output logic              o_par_err,
  output logic              o_out_valid,
  output logic              o_overrun,
  output logic [CNT_W-1:0]  o_err_cnt
);
  import serial_parity_rx_pkg::*;

  localparam int            CW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic          MODE = ODD ? serial_parity_rx_pkg::ODD : EVEN;

  state_t            r_state, w_next;
  logic              w_clr, w_shift, w_cap, w_hs, w_perr, w_acc;
  logic [DATA_W-1:0] w_shreg;
  logic [CW-1:0]     w_bit_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_par_calc, r_par_err, r_out_valid, r_overrun;
  logic [CNT_W-1:0]  r_err_cnt;

  serial_parity_acc #(.DATA_W(DATA_W), .CW(CW)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_shift   (w_shift),
    .i_bit     (i_bit_in),
    .o_shreg   (w_shreg),
    .o_acc     (w_acc),
    .o_bit_cnt (w_bit_cnt)
  );

  assign w_hs   = r_out_valid && i_out_ready;
  assign w_perr = w_acc ^ i_bit_in ^ MODE;

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_cap   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr  = i_bit_valid && !i_bit_in;
        w_next = w_clr ? SHIFT : IDLE;
      end
      SHIFT: begin
        w_shift = i_bit_valid;
        w_next  = (w_shift && w_bit_cnt == LAST) ? PAR : SHIFT;
      end
      PAR: begin
        w_cap  = i_bit_valid;
        w_next = w_cap ? HOLD : PAR;
      end
      HOLD:    w_next = w_hs ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // out_valid rises one edge after capture, so HOLD is entered with it still low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_par_calc  <= 1'b0;
      r_par_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_cap) begin
        r_data_out <= w_shreg;
        r_par_calc <= w_acc;
        r_par_err  <= w_perr;
      end
      r_out_valid <= (r_state == HOLD) && !w_hs;
      r_overrun   <= i_err_clr ? 1'b0 : (r_overrun || (r_state == HOLD && i_bit_valid));
      r_err_cnt   <= i_err_clr ? '0 :
                     (w_cap && w_perr && r_err_cnt != '1) ? r_err_cnt + 1'b1 : r_err_cnt;
    end
  end

  assign o_data_out  = r_data_out;
  assign o_par_calc  = r_par_calc;
  assign o_par_err   = r_par_err;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;
  assign o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: table vectors, directed corner sequences and random frames
// driven into default, CNT_W=2 and ODD=1 instances sharing one stimulus stream
module tb_serial_parity_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_bit_in = 1'b1, i_bit_valid = 1'b0, i_out_ready = 1'b1, i_err_clr = 1'b0;

  logic [3:0] d_data, s_data, x_data;
  logic       d_calc, d_err, d_valid, d_ovr;
  logic       s_calc, s_err, s_valid, s_ovr;
  logic       x_calc, x_err, x_valid, x_ovr;
  logic [7:0] d_cnt, x_cnt;
  logic [1:0] s_cnt;

  int n_tests = 0, n_fail = 0;
  int cnt_e = 0, cnt_s = 0, cnt_o = 0;

  always #5 clk = ~clk;

  serial_parity_rx dut (
    .clk(clk), .rst_n(rst_n), .i_bit_in(i_bit_in), .i_bit_valid(i_bit_valid),
    .i_out_ready(i_out_ready), .i_err_clr(i_err_clr), .o_data_out(d_data),
    .o_par_calc(d_calc), .o_par_err(d_err), .o_out_valid(d_valid),
    .o_overrun(d_ovr), .o_err_cnt(d_cnt));

  serial_parity_rx #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_bit_in(i_bit_in), .i_bit_valid(i_bit_valid),
    .i_out_ready(i_out_ready), .i_err_clr(i_err_clr), .o_data_out(s_data),
    .o_par_calc(s_calc), .o_par_err(s_err), .o_out_valid(s_valid),
    .o_overrun(s_ovr), .o_err_cnt(s_cnt));

  serial_parity_rx #(.ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .i_bit_in(i_bit_in), .i_bit_valid(i_bit_valid),
    .i_out_ready(i_out_ready), .i_err_clr(i_err_clr), .o_data_out(x_data),
    .o_par_calc(x_calc), .o_par_err(x_err), .o_out_valid(x_valid),
    .o_overrun(x_ovr), .o_err_cnt(x_cnt));

  typedef struct {
    logic [3:0] data;
    logic       pbit;
    logic [3:0] exp_data;
    logic       exp_calc;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_bit_in = b;
    i_bit_valid = 1'b1;
    @(negedge clk);
    i_bit_valid = 1'b0;
    i_bit_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Sends a whole frame and advances the error-count model by its outcome.
  task automatic send_frame(input logic [3:0] data, input logic pbit, input int gap);
    logic e;
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(data[i], gap);
    send_bit(pbit, 0);
    e = (^data) ^ pbit;
    if (e) begin
      cnt_e++;
      cnt_s = (cnt_s == 3) ? 3 : cnt_s + 1;
    end
    else cnt_o++;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!d_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] edata, input logic ecalc,
                             input logic eerr, input int rdly);
    int c;
    logic oerr;
    oerr = ~eerr;
    wait_valid(c);
    chk({tag, "_latency"}, c, 1);
    chk({tag, "_data"}, d_data, edata);
    chk({tag, "_par_calc"}, d_calc, ecalc);
    chk({tag, "_par_err"}, d_err, eerr);
    chk({tag, "_odd_par_err"}, x_err, oerr);
    chk({tag, "_err_cnt"}, d_cnt, cnt_e);
    chk({tag, "_sat_err_cnt"}, s_cnt, cnt_s);
    chk({tag, "_odd_err_cnt"}, x_cnt, cnt_o);
    repeat (rdly) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, d_valid, 1);
      chk({tag, "_hold_data"}, d_data, edata);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, d_valid, 0);
  endtask

  task automatic clear_errs();
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    cnt_e = 0; cnt_s = 0; cnt_o = 0;
    chk("clr_err_cnt", d_cnt, 0);
    chk("clr_sat_err_cnt", s_cnt, 0);
    chk("clr_overrun", d_ovr, 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [1:0] sat_exp[5];
    int c;
    tbl[0] = '{4'hD, 1'b1, 4'hD, 1'b1, 1'b0};
    tbl[1] = '{4'hD, 1'b0, 4'hD, 1'b1, 1'b1};
    tbl[2] = '{4'hD, 1'b0, 4'hD, 1'b1, 1'b1};
    tbl[3] = '{4'h6, 1'b0, 4'h6, 1'b0, 1'b0};
    tbl[4] = '{4'hF, 1'b1, 4'hF, 1'b0, 1'b1};
    tbl[5] = '{4'h8, 1'b1, 4'h8, 1'b1, 1'b0};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(negedge clk);
    chk("rst_data", d_data, 0);
    chk("rst_valid", d_valid, 0);
    chk("rst_err_cnt", d_cnt, 0);
    chk("rst_overrun", d_ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].pbit, 0);
      check_frame("tbl", tbl[i].exp_data, tbl[i].exp_calc, tbl[i].exp_err, 0);
    end
    clear_errs();

    i_out_ready = 1'b0;
    send_frame(4'hD, 1'b1, 0);
    wait_valid(c);
    chk("bp_latency", c, 1);
    for (int k = 0; k < 6; k++) begin
      i_bit_valid = (k % 2 == 0);
      i_bit_in = k[1];
      @(negedge clk);
      chk("bp_data", d_data, 4'hD);
      chk("bp_valid", d_valid, 1);
    end
    i_bit_valid = 1'b0;
    chk("bp_overrun", d_ovr, 1);
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", d_valid, 0);
    chk("bp_overrun_sticky", d_ovr, 1);
    @(negedge clk);
    chk("bp_overrun_sticky2", d_ovr, 1);
    clear_errs();

    i_out_ready = 1'b0;
    send_frame(4'h6, 1'b0, 0);
    wait_valid(c);
    i_out_ready = 1'b1;
    i_bit_valid = 1'b1;
    i_bit_in = 1'b0;
    @(negedge clk);
    i_bit_valid = 1'b0;
    i_bit_in = 1'b1;
    chk("hs_ovr_valid", d_valid, 0);
    chk("hs_ovr_overrun", d_ovr, 1);
    send_frame(4'h9, 1'b0, 0);
    check_frame("after_drop", 4'h9, 1'b0, 1'b0, 0);
    clear_errs();

    i_err_clr = 1'b1;
    send_frame(4'hD, 1'b0, 0);
    wait_valid(c);
    i_err_clr = 1'b0;
    chk("clr_wins_par_err", d_err, 1);
    chk("clr_wins_err_cnt", d_cnt, 0);
    chk("clr_wins_sat_cnt", s_cnt, 0);
    cnt_e = 0; cnt_s = 0; cnt_o = 0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      send_frame(4'hD, 1'b0, 0);
      wait_valid(c);
      chk("sat_seq", s_cnt, sat_exp[k]);
      chk("sat_full_cnt", d_cnt, k + 1);
      @(negedge clk);
    end

    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", d_data, 0);
    chk("midrst_calc", d_calc, 0);
    chk("midrst_err", d_err, 0);
    chk("midrst_err_cnt", d_cnt, 0);
    chk("midrst_sat_cnt", s_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_e = 0; cnt_s = 0; cnt_o = 0;
    @(negedge clk);
    send_frame(4'h6, 1'b0, 0);
    check_frame("midrst_next", 4'h6, 1'b0, 1'b0, 0);

    repeat (3) send_bit(1'b1, 0);
    send_frame(4'hD, 1'b1, 3);
    check_frame("gaps", 4'hD, 1'b1, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] data;
      logic pbit, calc, err;
      int gap, rdly;
      data = 4'($urandom);
      pbit = 1'($urandom);
      gap = $urandom_range(0, 2);
      rdly = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) send_bit(1'b1, 0);
      i_out_ready = (rdly == 0);
      send_frame(data, pbit, gap);
      calc = ^data;
      err = calc ^ pbit;
      check_frame("rand", data, calc, err, rdly);
    end
    chk("rand_no_overrun", d_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
Serial front end that feeds the team's nibble parity logic. It deserialises a bit stream into DATA_W-bit words, framed as one start bit, DATA_W data bits (LSB first) and one parity bit. It computes a running XOR of the data bits, checks it against the received parity bit, and presents the word with a valid/ready handshake. It also keeps a saturating parity-error counter and a sticky overrun flag.

Parameters:
DATA_W, 4, data bits per frame (minimum 2)
CNT_W, 8, width of the parity-error counter
ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = ~XOR of data)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  serial data, sampled only when bit_valid=1
bit_valid  input  1  qualifies bit_in for one cycle; gaps between bits are allowed
out_ready  input  1  downstream accepts the word
err_clr  input  1  synchronous clear of err_cnt and overrun
data_out  output  DATA_W  received word, LSB = first data bit
par_calc  output  1  XOR of data_out
par_err  output  1  parity mismatch for the current data_out
out_valid  output  1  data_out, par_calc and par_err are valid
overrun  output  1  sticky: a bit arrived while a word was held
err_cnt  output  CNT_W  saturating count of parity errors

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0 all state and outputs are 0 and the FSM is in IDLE.
- Reset mid-frame discards the partial frame. There is no recovery of the partial frame.
- FSM states: IDLE, SHIFT, PAR, HOLD. Registered outputs only.
- IDLE:
  - bit_valid with bit_in=0 (start bit) -> SHIFT; clear the shift register, running XOR acc and bit_cnt.
  - bit_valid with bit_in=1 is line idle and is ignored.
- SHIFT, on each bit_valid:
  - shreg <= {bit_in, shreg[DATA_W-1:1]}
  - acc <= acc ^ bit_in
  - bit_cnt <= bit_cnt + 1
  - The DATA_W-th bit moves the FSM to PAR.
- PAR, on bit_valid:
  - data_out <= shreg, par_calc <= acc, par_err <= acc ^ bit_in ^ ODD.
  - out_valid rises on the next edge; FSM -> HOLD.
  - Latency: parity bit sampled at edge N -> out_valid=1 after edge N+1.
- HOLD:
  - data_out, par_calc, par_err and out_valid are held stable until out_valid && out_ready.
  - On that handshake edge, out_valid <= 0 and FSM -> IDLE.
  - data_out and par_err keep their last values after the handshake and are don't-care while out_valid=0.
- Overrun:
  - Any bit_valid in HOLD sets overrun=1 and the bit is dropped.
  - This holds even when the same cycle completes the handshake.
- err_cnt:
  - +1 at the PAR edge when the computed par_err is 1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- err_clr=1:
  - Clears err_cnt and overrun on the next edge.
  - Clear wins over a simultaneous increment or overrun event.
  - err_clr does not affect the FSM or the data path.
- bit_valid=0 in any state: no change except the handshake.
- bit_cnt width is $clog2(DATA_W+1). It wraps only through the IDLE reload.

Decomposition:
- Shared package/header holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, PAR=2'd2, HOLD=2'd3
  - parity-mode constants EVEN=0, ODD=1
- One natural sub-module: serial_parity_acc. It holds shreg, acc and bit_cnt, with load/shift/clear controls driven by the FSM.
- The top level holds the FSM, the output registers, err_cnt and overrun.

Test Plan:
1. Good frame, default parameters: bits 0 | 1,0,1,1 | 1, one per cycle, out_ready=1 -> data_out=4'hD, par_calc=1, par_err=0, out_valid high one cycle after the parity bit, err_cnt=0.
2. Bad parity: 0 | 1,0,1,1 | 0 -> data_out=4'hD, par_err=1, err_cnt=1. Second identical frame -> err_cnt=2. Pulse err_clr -> err_cnt=0.
3. Back-pressure/overrun: good frame with out_ready=0 for 6 cycles, with bit_valid pulses during HOLD:
   - data_out stays 4'hD and out_valid stays 1, overrun=1.
   - Raising out_ready -> out_valid=0 next edge; overrun stays 1 until err_clr.
4. Saturation: CNT_W=2, five bad-parity frames -> err_cnt 1,2,3,3,3.
5. Reset mid-frame: rst_n low after two data bits -> all outputs 0 immediately. Next good frame 0 | 0,1,1,0 | 0 -> data_out=4'h6, par_err=0.
6. Gaps and idle/odd mode:
   - Idle 1s before the start bit, plus 3-cycle bit_valid gaps between bits -> same result as scenario 1.
   - ODD=1, frame 0 | 1,0,1,1 | 0 -> par_err=0.
